// File: rtl/sum_pkg.sv
// Shared constants and FSM state type for the nibble-serial adder sequencer.
package sum_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sum4b_ci.sv
// 4-bit ripple-carry adder with carry-in, built from single-bit full-adder cells.
// sum1b is the full-adder cell; sum4b_ci chains NIB_W of them.
module sum1b (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

module sum4b_ci
    import sum_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_ci,
    output logic [NIB_W-1:0] o_s,
    output logic             o_co
);

    logic [NIB_W:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar g = 0; g < NIB_W; g++) begin : g_bit
        sum1b u_fa (
            .i_a  (i_a[g]),
            .i_b  (i_b[g]),
            .i_ci (w_c[g]),
            .o_s  (o_s[g]),
            .o_co (w_c[g+1])
        );
    end

    assign o_co = w_c[NIB_W];

endmodule

// File: rtl/sum_seq_ctrl.sv
// Wide adder sequencer: reuses one 4-bit adder over NIBBLES cycles, LS nibble first.
// Optional subtract mode with signed-overflow flag when SUM_SEQ_SUB_EN is defined.
module sum_seq_ctrl
    import sum_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIB_W * NIBBLES,
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] So,
    output logic         Co
`ifdef SUM_SEQ_SUB_EN
    ,
    input  logic         Sub,
    output logic         Ov
`endif
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_opa;
    logic [W-1:0]       r_opb;
    logic [W-1:0]       r_so;
    logic               r_co;
    logic               r_busy;
    logic               r_done;
    logic               w_last;
    logic [NIB_W-1:0]   w_nib_a;
    logic [NIB_W-1:0]   w_nib_b;
    logic [NIB_W-1:0]   w_nib_s;
    logic               w_nib_co;
`ifdef SUM_SEQ_SUB_EN
    logic               r_ov;
    logic               w_c_msb;
`endif

    assign w_last  = (r_idx == IDX_W'(NIBBLES - 1));
    assign w_nib_a = r_opa[int'(r_idx) * NIB_W +: NIB_W];
    assign w_nib_b = r_opb[int'(r_idx) * NIB_W +: NIB_W];

    sum4b_ci u_nib_add (
        .i_a  (w_nib_a),
        .i_b  (w_nib_b),
        .i_ci (r_carry),
        .o_s  (w_nib_s),
        .o_co (w_nib_co)
    );

`ifdef SUM_SEQ_SUB_EN
    // Carry into the top bit is recovered from that bit's sum and operand bits.
    assign w_c_msb = w_nib_s[NIB_W-1] ^ w_nib_a[NIB_W-1] ^ w_nib_b[NIB_W-1];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, per-nibble result write-back, carry chaining and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_so    <= '0;
            r_co    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SUM_SEQ_SUB_EN
            r_ov    <= 1'b0;
`endif
        end else begin
            r_busy <= (w_state_nxt == ST_RUN);
            r_done <= (w_state_nxt == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opa <= A;
                        r_idx <= '0;
                        r_so  <= '0;
                        r_co  <= 1'b0;
`ifdef SUM_SEQ_SUB_EN
                        // Subtract as A + ~B + 1; Ci is irrelevant then.
                        r_opb   <= Sub ? ~B : B;
                        r_carry <= Sub ? 1'b1 : Ci;
`else
                        r_opb   <= B;
                        r_carry <= Ci;
`endif
                    end
                end
                ST_RUN: begin
                    r_so[int'(r_idx) * NIB_W +: NIB_W] <= w_nib_s;
                    r_carry <= w_nib_co;
                    // Index parks on the last nibble instead of wrapping.
                    if (w_last) begin
                        r_co <= w_nib_co;
`ifdef SUM_SEQ_SUB_EN
                        r_ov <= w_c_msb ^ w_nib_co;
`endif
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign So   = r_so;
    assign Co   = r_co;
`ifdef SUM_SEQ_SUB_EN
    assign Ov   = r_ov;
`endif

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Self-checking bench for sum_seq_ctrl (NIBBLES=4); covers SUM_SEQ_SUB_EN when defined.
module tb_sum_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Ci;
    logic         busy;
    logic         done;
    logic [W-1:0] So;
    logic         Co;
`ifdef SUM_SEQ_SUB_EN
    logic         Sub;
    logic         Ov;
`endif

    int checks = 0;
    int errors = 0;

    sum_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .busy  (busy),
        .done  (done),
        .So    (So),
        .Co    (Co)
`ifdef SUM_SEQ_SUB_EN
        ,
        .Sub   (Sub),
        .Ov    (Ov)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
        bit           chg;
        logic [W-1:0] so;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the whole operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sub, output logic [W-1:0] so, output logic co,
                         output logic ov);
        longint ua, ub, us, sa, sb, ss;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            us = ua - ub;
            ss = sa - sb;
            co = (ua >= ub);
        end else begin
            us = ua + ub + longint'(ci);
            ss = sa + sb + longint'(ci);
            co = (us >= (64'sd1 << W));
        end
        so = us[W-1:0];
        ov = (ss > ((64'sd1 << (W - 1)) - 64'sd1)) || (ss < -(64'sd1 << (W - 1)));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sub, input bit chg,
                          input logic [W-1:0] eso, input logic eco, input logic eov);
        @(negedge clk);
        A = a; B = b; Ci = ci; start = 1'b1;
`ifdef SUM_SEQ_SUB_EN
        Sub = sub;
`endif
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        check({tag, "_clr_so"}, {16'd0, So}, 32'd0);
        check({tag, "_clr_co"}, {31'd0, Co}, 32'd0);
        if (chg) begin
            A = ~a; B = ~b; Ci = ~ci;
`ifdef SUM_SEQ_SUB_EN
            Sub = ~sub;
`endif
        end
        for (int i = 1; i < NIB; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, {30'd0, busy, done}, 32'd2);
        end
        @(negedge clk);
        check({tag, "_done"}, {30'd0, busy, done}, 32'd1);
        check({tag, "_so"}, {16'd0, So}, {16'd0, eso});
        check({tag, "_co"}, {31'd0, Co}, {31'd0, eco});
`ifdef SUM_SEQ_SUB_EN
        check({tag, "_ov"}, {31'd0, Ov}, {31'd0, eov});
`endif
        @(negedge clk);
        check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_hold"}, {15'd0, Co, So}, {15'd0, eco, eso});
    endtask

    initial begin
        logic [W-1:0] ra, rb, mso;
        logic         rci, rsub, mco, mov;
        int           last_done, n_done, cyc, gap, bound;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Ci = 1'b0;
`ifdef SUM_SEQ_SUB_EN
        Sub = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        check("rst_flags", {30'd0, busy, done}, 32'd0);
        check("rst_res", {15'd0, Co, So}, 32'd0);
`ifdef SUM_SEQ_SUB_EN
        check("rst_ov", {31'd0, Ov}, 32'd0);
`endif
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
`ifndef SUM_SEQ_SUB_EN
            if (vecs[v].sub) continue;
`endif
            run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].ci, vecs[v].sub,
                   vecs[v].chg, vecs[v].so, vecs[v].co, vecs[v].ov);
        end

        // start held high: ops repeat, start during RUN/DONE must not shorten the cycle.
        @(negedge clk);
        A = 16'h0F0F; B = 16'h0101; Ci = 1'b0; start = 1'b1;
`ifdef SUM_SEQ_SUB_EN
        Sub = 1'b0;
`endif
        last_done = -1; n_done = 0;
        for (cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (busy && done) check("hold_excl", 32'd1, 32'd0);
            if (done) begin
                n_done++;
                check("hold_res", {15'd0, Co, So}, {15'd0, 1'b0, 16'h1010});
                if (last_done >= 0) begin
                    gap = cyc - last_done;
                    check("hold_gap", {31'd0, (gap >= NIB + 1) && (gap <= NIB + 2)}, 32'd1);
                end
                last_done = cyc;
            end
        end
        start = 1'b0;
        check("hold_count", {31'd0, n_done >= 4}, 32'd1);
        bound = 0;
        while ((busy || done) && bound < 12) begin
            @(negedge clk);
            bound++;
        end
        check("hold_drain", {31'd0, busy || done}, 32'd0);

        // Reset during the second RUN cycle discards the operation.
        @(negedge clk);
        A = 16'hAAAA; B = 16'h5555; Ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", {30'd0, busy, done}, 32'd0);
        check("mid_rst_res", {15'd0, Co, So}, 32'd0);
        n_done = 0;
        for (int i = 0; i < NIB + 2; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("mid_no_done", n_done, 32'd0);
        run_op("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Randomised operations against the reference model.
        for (int r = 0; r < 40; r++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rci = 1'($urandom_range(0, 1));
`ifdef SUM_SEQ_SUB_EN
            rsub = 1'($urandom_range(0, 1));
`else
            rsub = 1'b0;
`endif
            model(ra, rb, rci, rsub, mso, mco, mov);
            run_op($sformatf("rnd%0d", r), ra, rb, rci, rsub, (r % 3) == 0, mso, mco, mov);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
